// File: rtl/uart_tx_mmio_if.sv
// Data-bus responder interface for uart_tx_mmio (ce/we/addr/data_i/data_o).
interface uart_tx_mmio_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output ce, we, addr, data_i,
        input  data_o
    );

    modport slave (
        input  ce, we, addr, data_i,
        output data_o
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TX FIFO + 8N1 serializer on the data bus.
// Optional UART_TX_PARITY_EN adds an even/odd parity bit (CTRL bit17 = odd).
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] CLK_DIV    = 16'd16
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_mmio_if.slave bus,
    output logic          tx,
    output logic          irq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_e;

    state_e      state_q;
    logic        tx_q;
    logic [7:0]  sh_q;
    logic [15:0] div_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_q;
    logic        irq_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   divr_q, divr_d;
    logic          irq_en_q, irq_en_d;
`ifdef UART_TX_PARITY_EN
    logic          odd_q, odd_d;
    logic          par_q;
`endif

    logic        hit;
    logic [1:0]  sel;
    logic        push, push_ok, pop;
    logic        ctrl_wr, stat_wr;
    logic        full, empty, busy;
    logic [6:0]  cnt7;
    logic [31:0] status, ctrl, rdata;
    logic        unused_ok;

    assign hit     = bus.ce && (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign sel     = bus.addr[3:2];
    assign push    = hit && bus.we && (sel == 2'd0);
    assign stat_wr = hit && bus.we && (sel == 2'd1);
    assign ctrl_wr = hit && bus.we && (sel == 2'd2);

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign busy  = (state_q != IDLE);
    assign cnt7  = 7'(count_q);

    // Head is consumed either from IDLE or at the last STOP cycle (no gap).
    assign pop = !empty &&
                 ((state_q == IDLE) ||
                  (state_q == STOP && baud_q == 16'd0));
    assign push_ok = push && (!full || pop);

    assign unused_ok = ^{bus.addr[1:0], bus.data_i[31:16]};

    always_comb begin
        wptr_d   = wptr_q + AW'(push_ok);
        rptr_d   = rptr_q + AW'(pop);
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        ovf_d    = ovf_q;
        divr_d   = divr_q;
        irq_en_d = irq_en_q;
`ifdef UART_TX_PARITY_EN
        odd_d    = odd_q;
`endif
        if (stat_wr && bus.data_i[3]) ovf_d = 1'b0;
        if (push && full && !pop)     ovf_d = 1'b1;
        if (ctrl_wr) begin
            divr_d   = (bus.data_i[15:0] == 16'd0) ?
                       16'd1 : bus.data_i[15:0];
            irq_en_d = bus.data_i[16];
`ifdef UART_TX_PARITY_EN
            odd_d    = bus.data_i[17];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            divr_q   <= CLK_DIV;
            irq_en_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            odd_q    <= 1'b0;
`endif
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            divr_q   <= divr_d;
            irq_en_q <= irq_en_d;
`ifdef UART_TX_PARITY_EN
            odd_q    <= odd_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= bus.data_i[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            sh_q    <= '0;
            div_q   <= CLK_DIV;
            baud_q  <= '0;
            bit_q   <= '0;
            irq_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            irq_q <= irq_en_q && empty && (state_q == IDLE);
            if (pop) begin
                state_q <= START;
                tx_q    <= 1'b0;
                sh_q    <= mem_q[rptr_q];
                div_q   <= divr_q;
                baud_q  <= divr_q - 16'd1;
                bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
                par_q   <= (^mem_q[rptr_q]) ^ odd_q;
`endif
            end else if (state_q != IDLE && baud_q != 16'd0) begin
                baud_q <= baud_q - 16'd1;
            end else begin
                baud_q <= div_q - 16'd1;
                unique case (state_q)
                    IDLE: begin
                        tx_q <= 1'b1;
                    end
                    START: begin
                        state_q <= DATA;
                        tx_q    <= sh_q[0];
                    end
                    DATA: begin
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            sh_q  <= sh_q >> 1;
                            tx_q  <= sh_q[1];
                        end
                    end
                    PARITY: begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        status = {17'd0, cnt7, 4'd0, ovf_q, busy, empty, full};
`ifdef UART_TX_PARITY_EN
        ctrl   = {14'd0, odd_q, irq_en_q, divr_q};
`else
        ctrl   = {15'd0, irq_en_q, divr_q};
`endif
        rdata  = '0;
        if (hit && !bus.we) begin
            unique case (sel)
                2'd1:    rdata = status;
                2'd2:    rdata = ctrl;
                default: rdata = '0;
            endcase
        end
    end

    assign bus.data_o = rdata;
    assign tx         = tx_q;
    assign irq        = irq_q;
endmodule
